fwd_tracker: RTL and testbench

//  Parametrised operand-forwarding/hazard tracker for the in-order RISC-V pipeline; generalises the fixed EX/MEM/WB forwarding unit.

---
 rtl/fwd_tracker.sv | 184 ++++++++++++++++++
 tb/tb_fwd_tracker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_tracker.sv
// -----------------------------------------------------------------------------
// fwd_tracker
//   Operand-forwarding / hazard tracker for the in-order pipeline.
//   Keeps a shift-register table of the destinations of the instructions in
//   the STAGES stages after ID (entry 0 = EX, entry STAGES-1 = WB) and
//   resolves NUM_SRC source operands in ID against it every cycle.
//   Each operand takes the youngest matching producer. A producer whose value
//   has not been computed yet raises stall_o; the operand then falls back to
//   the register file. A producer in WB still forwards, because the register
//   file write lands on the same edge as the read.
//
//   Issue handshake: issue_valid_i qualifies the issue_* fields. The
//   instruction enters entry 0 only on an edge where issue_valid_i && !stall_o
//   && !flush_i && !hold_i. stall_o is the only back-pressure signal and is
//   never asserted while issue_valid_i is low.
//
// Optional feature macro: FWD_PERF_CNT_EN
//   Defined     : perf_stall_o / perf_fwd_o are saturating event counters.
//   Not defined : both ports are tied to zero and no counter flops exist.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   hold_i          pipeline freeze; the table keeps its contents
//   flush_i         drops the issuing instruction and the one leaving EX
//   issue_valid_i   instruction leaves ID this cycle
//   issue_we_i      it writes rd
//   issue_rd_i      its destination register
//   issue_rdy_i     first stage index whose output holds its result
//   stage_data_i    per-stage result values, slice k = stage k
//   src_addr_i      source register indices read in ID, slice s = source s
//   rf_data_i       register-file read data, slice s = source s
//   fwd_data_o      resolved operand per source
//   fwd_sel_o       0 = register file, k+1 = forwarded from stage k
//   stall_o         some operand is not available yet; ID must hold
//   perf_stall_o    stall-cycle counter
//   perf_fwd_o      forwarded-operand counter
// -----------------------------------------------------------------------------
module fwd_tracker #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STAGES         = 3,
   parameter int NUM_SRC        = 2,
   localparam int SEL_W         = $clog2(STAGES + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             hold_i,
   input  logic                             flush_i,
   input  logic                             issue_valid_i,
   input  logic                             issue_we_i,
   input  logic [REG_ADDR_WIDTH-1:0]        issue_rd_i,
   input  logic [SEL_W-1:0]                 issue_rdy_i,
   input  logic [STAGES*DATA_WIDTH-1:0]     stage_data_i,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]    rf_data_i,
   output logic [NUM_SRC*DATA_WIDTH-1:0]    fwd_data_o,
   output logic [NUM_SRC*SEL_W-1:0]         fwd_sel_o,
   output logic                             stall_o,
   output logic [31:0]                      perf_stall_o,
   output logic [31:0]                      perf_fwd_o
);

   // Producer table, one entry per tracked stage.
   logic [STAGES-1:0]         ent_v;
   logic [STAGES-1:0]         ent_we;
   logic [REG_ADDR_WIDTH-1:0] ent_rd  [STAGES];
   logic [SEL_W-1:0]          ent_rdy [STAGES];

   logic issue_fire;
   assign issue_fire = issue_valid_i && !stall_o && !flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_v  <= '0;
         ent_we <= '0;
         for (int k = 0; k < STAGES; k++) begin
            ent_rd[k]  <= '0;
            ent_rdy[k] <= '0;
         end
      end else if (!hold_i) begin
         for (int k = 1; k < STAGES; k++) begin
            ent_v[k]   <= ent_v[k-1];
            ent_we[k]  <= ent_we[k-1];
            ent_rd[k]  <= ent_rd[k-1];
            ent_rdy[k] <= ent_rdy[k-1];
         end
         ent_v[0]   <= issue_fire;
         ent_we[0]  <= issue_we_i;
         ent_rd[0]  <= issue_rd_i;
         ent_rdy[0] <= issue_rdy_i;
         // The instruction that was in EX is on the wrong path as well.
         if (flush_i) begin
            ent_v[1] <= 1'b0;
         end
      end
   end

   // Lookup temporaries.
   logic                      stall_any;
   logic                      hit;
   logic [SEL_W-1:0]          hit_age;
   logic [SEL_W-1:0]          hit_sel;
   logic [SEL_W-1:0]          hit_rdy;
   logic [DATA_WIDTH-1:0]     hit_data;
   logic [REG_ADDR_WIDTH-1:0] src;

   always_comb begin
      stall_any  = 1'b0;
      fwd_sel_o  = '0;
      fwd_data_o = rf_data_i;
      hit        = 1'b0;
      hit_age    = '0;
      hit_sel    = '0;
      hit_rdy    = '0;
      hit_data   = '0;
      src        = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src      = src_addr_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         hit      = 1'b0;
         hit_age  = '0;
         hit_sel  = '0;
         hit_rdy  = '0;
         hit_data = '0;
         // Scan oldest to youngest so the youngest match overwrites.
         for (int k = STAGES - 1; k >= 0; k--) begin
            if (ent_v[k] && ent_we[k] && (ent_rd[k] == src) && (src != '0)) begin
               hit      = 1'b1;
               hit_age  = SEL_W'(k);
               hit_sel  = SEL_W'(k + 1);
               hit_rdy  = ent_rdy[k];
               hit_data = stage_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (hit) begin
            if (hit_age >= hit_rdy) begin
               fwd_sel_o[s*SEL_W +: SEL_W]           = hit_sel;
               fwd_data_o[s*DATA_WIDTH +: DATA_WIDTH] = hit_data;
            end else begin
               stall_any = 1'b1;
            end
         end
      end
   end

   assign stall_o = issue_valid_i && stall_any;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_fwd_q;
   logic [32:0] fwd_sum;

   // Running total plus this cycle's forwarded operands, one bit wider so
   // saturation can be detected.
   always_comb begin
      fwd_sum = {1'b0, perf_fwd_q};
      for (int s = 0; s < NUM_SRC; s++) begin
         if (fwd_sel_o[s*SEL_W +: SEL_W] != '0) begin
            fwd_sum = fwd_sum + 33'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_fwd_q   <= '0;
      end else begin
         if (stall_o && !hold_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (issue_valid_i && !stall_o && !hold_i) begin
            perf_fwd_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
         end
      end
   end

   assign perf_stall_o = perf_stall_q;
   assign perf_fwd_o   = perf_fwd_q;
`else
   assign perf_stall_o = '0;
   assign perf_fwd_o   = '0;
`endif

endmodule

// File: tb/tb_fwd_tracker.sv
module tb_fwd_tracker;

   localparam int DW    = 32;
   localparam int RW    = 5;
   localparam int ST    = 3;
   localparam int NS    = 2;
   localparam int SW    = $clog2(ST + 1);
   localparam int EXP_W = 1 + NS*SW + NS*DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 hold_i;
   logic                 flush_i;
   logic                 issue_valid_i;
   logic                 issue_we_i;
   logic [RW-1:0]        issue_rd_i;
   logic [SW-1:0]        issue_rdy_i;
   logic [ST*DW-1:0]     stage_data_i;
   logic [NS*RW-1:0]     src_addr_i;
   logic [NS*DW-1:0]     rf_data_i;
   logic [NS*DW-1:0]     fwd_data_o;
   logic [NS*SW-1:0]     fwd_sel_o;
   logic                 stall_o;
   logic [31:0]          perf_stall_o;
   logic [31:0]          perf_fwd_o;

   fwd_tracker #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .STAGES(ST), .NUM_SRC(NS)
   ) dut (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
      .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i),
      .issue_rd_i(issue_rd_i), .issue_rdy_i(issue_rdy_i),
      .stage_data_i(stage_data_i), .src_addr_i(src_addr_i),
      .rf_data_i(rf_data_i), .fwd_data_o(fwd_data_o), .fwd_sel_o(fwd_sel_o),
      .stall_o(stall_o), .perf_stall_o(perf_stall_o), .perf_fwd_o(perf_fwd_o)
   );

   // ---------------- reference model ----------------
   // In-flight instructions listed by age: mq[0] issued last edge.
   typedef struct {
      logic          v;
      logic          we;
      logic [RW-1:0] rd;
      logic [SW-1:0] rdy;
   } inflight_t;

   inflight_t  mq[$];
   logic       m_stall = 1'b0;
   int         m_nfwd  = 0;
   logic [NS*SW-1:0] m_sel;
   logic [NS*DW-1:0] m_data;
   logic [31:0] m_perf_stall = '0;
   logic [31:0] m_perf_fwd   = '0;

   // inputs captured for the coming edge
   logic          p_rst, p_hold, p_flush, p_valid, p_we, p_stall;
   logic [RW-1:0] p_rd;
   logic [SW-1:0] p_rdy;
   int            p_nfwd;

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_lookup();
      logic          any;
      logic [RW-1:0] s_addr;
      logic          found;
      any    = 1'b0;
      m_nfwd = 0;
      m_sel  = '0;
      m_data = rf_data_i;
      for (int s = 0; s < NS; s++) begin
         s_addr = src_addr_i[s*RW +: RW];
         found  = 1'b0;
         for (int a = 0; a < mq.size(); a++) begin
            if (!found && mq[a].v && mq[a].we && mq[a].rd == s_addr && s_addr != 0) begin
               found = 1'b1;
               if (a >= int'(mq[a].rdy)) begin
                  m_sel[s*SW +: SW]  = SW'(a + 1);
                  m_data[s*DW +: DW] = stage_data_i[a*DW +: DW];
                  m_nfwd++;
               end else begin
                  any = 1'b1;
               end
            end
         end
      end
      m_stall = issue_valid_i && any;
   endtask

   task automatic model_edge();
      inflight_t e;
      logic [32:0] sum;
      if (p_rst) begin
         mq.delete();
         m_perf_stall = '0;
         m_perf_fwd   = '0;
      end else if (!p_hold) begin
         e.v   = p_valid && !p_stall && !p_flush;
         e.we  = p_we;
         e.rd  = p_rd;
         e.rdy = p_rdy;
         mq.push_front(e);
         if (p_flush && mq.size() > 1) mq[1].v = 1'b0;
         while (mq.size() > ST) void'(mq.pop_back());
      end
`ifdef FWD_PERF_CNT_EN
      if (!p_rst && !p_hold) begin
         if (p_stall && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall = m_perf_stall + 1;
         if (p_valid && !p_stall) begin
            sum = {1'b0, m_perf_fwd} + 33'(p_nfwd);
            m_perf_fwd = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
         end
      end
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      rst = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
      issue_valid_i = 1'b0; issue_we_i = 1'b0; issue_rd_i = '0; issue_rdy_i = '0;
      stage_data_i = {32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
      src_addr_i = '0;
      rf_data_i = {32'hF1F1_1111, 32'hF0F0_0000};
   endtask

   task automatic issue(input logic [RW-1:0] rd, input logic [SW-1:0] rdy);
      issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = rd; issue_rdy_i = rdy;
   endtask

   // settle, compare every output with the model
   task automatic eval();
      logic [EXP_W-1:0] e;
      #2;
      model_lookup();
      exp_q.push_back({m_stall, m_sel, m_data});
      e = exp_q.pop_front();
      chk("stall", 32'(stall_o), 32'(e[EXP_W-1]));
      for (int s = 0; s < NS; s++) begin
         chk($sformatf("sel%0d", s), 32'(fwd_sel_o[s*SW +: SW]), 32'(e[NS*DW + s*SW +: SW]));
         chk($sformatf("data%0d", s), fwd_data_o[s*DW +: DW], e[s*DW +: DW]);
      end
      chk("perf_stall", perf_stall_o, m_perf_stall);
      chk("perf_fwd", perf_fwd_o, m_perf_fwd);
   endtask

   task automatic tick();
      p_rst = rst; p_hold = hold_i; p_flush = flush_i; p_valid = issue_valid_i;
      p_we = issue_we_i; p_rd = issue_rd_i; p_rdy = issue_rdy_i;
      p_stall = m_stall; p_nfwd = m_nfwd;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      set_idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // reset state
      eval();
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_sel", 32'(fwd_sel_o), 32'd0);
      chk("rst_data0", fwd_data_o[31:0], 32'hF0F0_0000);

      // 1: ALU result forwarded from EX
      issue(5'd1, 2'd0); eval(); tick();
      set_idle(); src_addr_i[4:0] = 5'd1; stage_data_i[31:0] = 32'd10;
      eval();
      chk("t1_sel0", 32'(fwd_sel_o[1:0]), 32'd1);
      chk("t1_data0", fwd_data_o[31:0], 32'd10);
      chk("t1_stall", 32'(stall_o), 32'd0);
      tick();

      // 2: load-use stalls one cycle, then forwards from MEM
      set_idle(); issue(5'd5, 2'd1); eval(); tick();
      set_idle(); issue_valid_i = 1'b1; src_addr_i[9:5] = 5'd5;
      eval();
      chk("t2_stall", 32'(stall_o), 32'd1);
      chk("t2_sel1_stall", 32'(fwd_sel_o[3:2]), 32'd0);
      chk("t2_data1_stall", fwd_data_o[63:32], 32'hF1F1_1111);
      tick();
      stage_data_i[63:32] = 32'h0000_0055;
      eval();
      chk("t2_stall_after", 32'(stall_o), 32'd0);
      chk("t2_sel1", 32'(fwd_sel_o[3:2]), 32'd2);
      chk("t2_data1", fwd_data_o[63:32], 32'h0000_0055);
`ifdef FWD_PERF_CNT_EN
      chk("t2_perf_stall", perf_stall_o, 32'd1);
`else
      chk("t2_perf_stall", perf_stall_o, 32'd0);
`endif
      tick();

      // 3: youngest producer wins
      set_idle(); issue(5'd3, 2'd0); eval(); tick();
      set_idle(); issue(5'd9, 2'd0); eval(); tick();
      set_idle(); issue(5'd3, 2'd0); eval(); tick();
      set_idle(); src_addr_i[4:0] = 5'd3;
      stage_data_i[31:0] = 32'd20; stage_data_i[95:64] = 32'd7;
      eval();
      chk("t3_sel0", 32'(fwd_sel_o[1:0]), 32'd1);
      chk("t3_data0", fwd_data_o[31:0], 32'd20);
      tick();

      // 4: x0 never forwards
      set_idle(); issue(5'd0, 2'd0); eval(); tick();
      set_idle(); issue_valid_i = 1'b1; stage_data_i[31:0] = 32'd99;
      rf_data_i[31:0] = 32'h0000_1234;
      eval();
      chk("t4_sel0", 32'(fwd_sel_o[1:0]), 32'd0);
      chk("t4_data0", fwd_data_o[31:0], 32'h0000_1234);
      chk("t4_stall", 32'(stall_o), 32'd0);
      tick();

      // 5: hold keeps the table (flush ignored under hold), then flush of EX
      set_idle(); issue(5'd2, 2'd0); eval(); tick();
      set_idle(); eval(); tick();
      for (int i = 0; i < 3; i++) begin
         set_idle(); hold_i = 1'b1; flush_i = (i == 1);
         src_addr_i[4:0] = 5'd2; stage_data_i[63:32] = 32'h0000_0022;
         eval();
         chk($sformatf("t5_hold_sel%0d", i), 32'(fwd_sel_o[1:0]), 32'd2);
         chk($sformatf("t5_hold_data%0d", i), fwd_data_o[31:0], 32'h0000_0022);
         tick();
      end
      set_idle(); src_addr_i[4:0] = 5'd2; stage_data_i[63:32] = 32'h0000_0022;
      eval();
      chk("t5_after_hold_sel", 32'(fwd_sel_o[1:0]), 32'd2);
      tick();
      set_idle(); issue(5'd4, 2'd0); eval(); tick();
      set_idle(); flush_i = 1'b1; eval(); tick();
      set_idle(); src_addr_i[4:0] = 5'd4;
      eval();
      chk("t5_flush_sel", 32'(fwd_sel_o[1:0]), 32'd0);
      chk("t5_flush_data", fwd_data_o[31:0], 32'hF0F0_0000);
      tick();

      // 6: reset drops a pending load
      set_idle(); issue(5'd6, 2'd2); eval(); tick();
      set_idle(); issue_valid_i = 1'b1; src_addr_i[4:0] = 5'd6;
      eval();
      chk("t6_stall_before", 32'(stall_o), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      eval();
      chk("t6_stall", 32'(stall_o), 32'd0);
      chk("t6_sel", 32'(fwd_sel_o), 32'd0);
      chk("t6_perf_stall", perf_stall_o, 32'd0);
      tick();

      // randomized phase
      for (int n = 0; n < 3000; n++) begin
         int r;
         rst           = ($urandom_range(0, 63) == 0);
         hold_i        = ($urandom_range(0, 7) == 0);
         flush_i       = ($urandom_range(0, 9) == 0);
         issue_valid_i = ($urandom_range(0, 3) != 0);
         issue_we_i    = ($urandom_range(0, 3) != 0);
         issue_rd_i    = RW'($urandom_range(0, 4));
         r = $urandom_range(0, 9);
         issue_rdy_i   = (r < 6) ? 2'd0 : (r < 9) ? 2'd1 : SW'($urandom_range(2, 3));
         src_addr_i    = {RW'($urandom_range(0, 4)), RW'($urandom_range(0, 4))};
         stage_data_i  = {$urandom(), $urandom(), $urandom()};
         rf_data_i     = {$urandom(), $urandom()};
         eval();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
